// File: rtl/router_fsm_pkg.sv
// Shared definitions for the 1x3 router write controller: state encoding,
// destination address constants and small decode helpers.
package router_pkg;

  // Width of the header destination field (data[1:0]).
  localparam int ADDR_WIDTH = 2;

  // Destination address values carried in the header byte.
  localparam logic [ADDR_WIDTH-1:0] ADDR_P0      = 2'd0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_P1      = 2'd1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_P2      = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] ADDR_INVALID = 2'd3;

  // Controller state: 8 states, binary 3-bit encoding. Kept as plain
  // logic constants so legacy code comparing raw encodings still works.
  typedef logic [2:0] state_t;

  localparam state_t DECODE_ADDRESS     = 3'd0;
  localparam state_t LOAD_FIRST_DATA    = 3'd1;
  localparam state_t LOAD_DATA          = 3'd2;
  localparam state_t FIFO_FULL_STATE    = 3'd3;
  localparam state_t LOAD_AFTER_FULL    = 3'd4;
  localparam state_t LOAD_PARITY        = 3'd5;
  localparam state_t CHECK_PARITY_ERROR = 3'd6;
  localparam state_t WAIT_TILL_EMPTY    = 3'd7;

  // Select the per-port flag addressed by addr; the invalid address
  // selects nothing and returns 0.
  function automatic logic sel_port(input logic [ADDR_WIDTH-1:0] addr,
                                    input logic                  flag_0,
                                    input logic                  flag_1,
                                    input logic                  flag_2);
    logic result;
    case (addr)
      ADDR_P0: result = flag_0;
      ADDR_P1: result = flag_1;
      ADDR_P2: result = flag_2;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Source-side handshake of the router: header/payload valid, header
// destination field and the busy back-pressure returned to the source.
interface router_fsm_if;
  import router_pkg::*;

  logic                  pkt_valid;
  logic [ADDR_WIDTH-1:0] datain;
  logic                  busy;

  // Packet source view: drives valid/data, observes busy.
  modport master (
    output pkt_valid,
    output datain,
    input  busy
  );

  // Write controller view: observes valid/data, drives busy.
  modport slave (
    input  pkt_valid,
    input  datain,
    output busy
  );

endinterface

// File: rtl/router_fsm.sv
// Packet-level write controller for the 1x3 router. Moore FSM: decodes the
// header destination, waits for the addressed FIFO to drain, then sequences
// the register/synchronizer stages through data, stall and parity phases.
module router_fsm
  import router_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  router_fsm_if.slave  src,
  input  logic         fifo_full,
  input  logic         fifo_empty_0,
  input  logic         fifo_empty_1,
  input  logic         fifo_empty_2,
  input  logic         soft_reset_0,
  input  logic         soft_reset_1,
  input  logic         soft_reset_2,
  input  logic         parity_done,
  input  logic         low_pkt_valid,
  output logic         detect_add,
  output logic         lfd_state,
  output logic         ld_state,
  output logic         laf_state,
  output logic         full_state,
  output logic         write_enb_reg,
  output logic         rst_int_reg
);

  state_t                state_q;
  state_t                next_state_s;
  logic [ADDR_WIDTH-1:0] addr_q;

  // Timeout reset of the port this packet is addressed to; the other
  // ports' timeouts do not concern the packet in flight.
  logic soft_reset_hit_s;
  // Empty flag of the port named by the incoming header byte.
  logic hdr_empty_s;
  // Empty flag of the latched destination port.
  logic addr_empty_s;
  // Header names one of the three real ports.
  logic hdr_valid_addr_s;

  // Source/port selection decode shared by the next-state logic.
  always_comb begin
    soft_reset_hit_s = sel_port(addr_q, soft_reset_0, soft_reset_1, soft_reset_2);
    hdr_empty_s      = sel_port(src.datain, fifo_empty_0, fifo_empty_1, fifo_empty_2);
    addr_empty_s     = sel_port(addr_q, fifo_empty_0, fifo_empty_1, fifo_empty_2);
    if (src.datain != ADDR_INVALID) begin
      hdr_valid_addr_s = 1'b1;
    end else begin
      hdr_valid_addr_s = 1'b0;
    end
  end

  // Next-state logic: soft reset of the addressed port overrides all
  // normal transitions.
  always_comb begin
    next_state_s = DECODE_ADDRESS;
    if (soft_reset_hit_s) begin
      next_state_s = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS: begin
          if (src.pkt_valid && hdr_valid_addr_s) begin
            if (hdr_empty_s) begin
              next_state_s = LOAD_FIRST_DATA;
            end else begin
              next_state_s = WAIT_TILL_EMPTY;
            end
          end else begin
            // Invalid destination or no packet: drop and keep decoding.
            next_state_s = DECODE_ADDRESS;
          end
        end
        LOAD_FIRST_DATA: begin
          next_state_s = LOAD_DATA;
        end
        LOAD_DATA: begin
          if (fifo_full) begin
            next_state_s = FIFO_FULL_STATE;
          end else if (!src.pkt_valid) begin
            next_state_s = LOAD_PARITY;
          end else begin
            next_state_s = LOAD_DATA;
          end
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) begin
            next_state_s = LOAD_AFTER_FULL;
          end else begin
            next_state_s = FIFO_FULL_STATE;
          end
        end
        LOAD_AFTER_FULL: begin
          if (parity_done) begin
            next_state_s = DECODE_ADDRESS;
          end else if (low_pkt_valid) begin
            next_state_s = LOAD_PARITY;
          end else begin
            next_state_s = LOAD_DATA;
          end
        end
        LOAD_PARITY: begin
          next_state_s = CHECK_PARITY_ERROR;
        end
        CHECK_PARITY_ERROR: begin
          if (fifo_full) begin
            next_state_s = FIFO_FULL_STATE;
          end else begin
            next_state_s = DECODE_ADDRESS;
          end
        end
        WAIT_TILL_EMPTY: begin
          if (addr_empty_s) begin
            next_state_s = LOAD_FIRST_DATA;
          end else begin
            next_state_s = WAIT_TILL_EMPTY;
          end
        end
        default: begin
          next_state_s = DECODE_ADDRESS;
        end
      endcase
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DECODE_ADDRESS;
    end else begin
      state_q <= next_state_s;
    end
  end

  // Destination latch: captured on every header cycle that has a valid
  // byte, so WAIT_TILL_EMPTY and soft-reset matching use this packet's port.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= ADDR_P0;
    end else if ((state_q == DECODE_ADDRESS) && src.pkt_valid) begin
      addr_q <= src.datain;
    end else begin
      addr_q <= addr_q;
    end
  end

  // Moore output decode from the state register only.
  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    src.busy      = 1'b0;
    case (state_q)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
      end
      LOAD_FIRST_DATA: begin
        lfd_state = 1'b1;
        src.busy  = 1'b1;
      end
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
      end
      FIFO_FULL_STATE: begin
        full_state = 1'b1;
        src.busy   = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
        src.busy      = 1'b1;
      end
      LOAD_PARITY: begin
        write_enb_reg = 1'b1;
        src.busy      = 1'b1;
      end
      CHECK_PARITY_ERROR: begin
        rst_int_reg = 1'b1;
        src.busy    = 1'b1;
      end
      WAIT_TILL_EMPTY: begin
        src.busy = 1'b1;
      end
      default: begin
        detect_add = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed, table-driven bench for the router write controller.
module tb_router_fsm;

  logic clk;
  logic reset;
  logic fifo_full;
  logic fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic soft_reset_0, soft_reset_1, soft_reset_2;
  logic parity_done, low_pkt_valid;
  logic detect_add, lfd_state, ld_state, laf_state, full_state;
  logic write_enb_reg, rst_int_reg;

  router_fsm_if src_if ();

  router_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .src           (src_if.slave),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .write_enb_reg (write_enb_reg),
    .rst_int_reg   (rst_int_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle order: {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
  localparam logic [7:0] O_DEC  = 8'b1000_0000;
  localparam logic [7:0] O_LFD  = 8'b0100_0001;
  localparam logic [7:0] O_LD   = 8'b0010_0100;
  localparam logic [7:0] O_LAF  = 8'b0001_0101;
  localparam logic [7:0] O_FULL = 8'b0000_1001;
  localparam logic [7:0] O_LP   = 8'b0000_0101;
  localparam logic [7:0] O_CPE  = 8'b0000_0011;
  localparam logic [7:0] O_WTE  = 8'b0000_0001;

  typedef struct {
    logic       rst;
    logic       pv;
    logic [1:0] din;
    logic       ff;
    logic [2:0] emp;   // {e2,e1,e0}
    logic [2:0] sr;    // {sr2,sr1,sr0}
    logic       pd;
    logic       lpv;
    logic [7:0] exp_o;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_fail;

  function automatic vec_t mk(input logic rst, input logic pv, input logic [1:0] din,
                              input logic ff, input logic [2:0] emp, input logic [2:0] sr,
                              input logic pd, input logic lpv, input logic [7:0] exp_o,
                              input string name);
    vec_t v;
    v.rst = rst; v.pv = pv; v.din = din; v.ff = ff; v.emp = emp; v.sr = sr;
    v.pd = pd; v.lpv = lpv; v.exp_o = exp_o; v.name = name;
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {detect_add, lfd_state, ld_state, laf_state, full_state,
            write_enb_reg, rst_int_reg, src_if.busy};
  endfunction

  task automatic drive(input vec_t v);
    reset         = v.rst;
    src_if.pkt_valid = v.pv;
    src_if.datain = v.din;
    fifo_full     = v.ff;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = v.emp;
    {soft_reset_2, soft_reset_1, soft_reset_0} = v.sr;
    parity_done   = v.pd;
    low_pkt_valid = v.lpv;
  endtask

  task automatic check(input string name, input logic [7:0] exp_o);
    logic [7:0] got;
    got = outs();
    n_checks++;
    if (got !== exp_o) begin
      n_fail++;
      $display("FAIL %s: outputs=%b expected=%b", name, got, exp_o);
    end
  endtask

  initial begin
    drive(mk(1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, O_DEC, "init"));
    n_checks = 0;
    n_fail   = 0;

    // rst pv din ff emp sr pd lpv expected
    vecs.push_back(mk(1, 0, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_DEC,  "reset"));
    vecs.push_back(mk(0, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, O_LFD,  "hdr1_lfd"));
    vecs.push_back(mk(0, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, O_LD,   "lfd_to_ld"));
    vecs.push_back(mk(0, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, O_LD,   "ld_stay"));
    vecs.push_back(mk(0, 0, 2'd0, 0, 3'b010, 3'b000, 0, 0, O_LP,   "ld_to_lp"));
    vecs.push_back(mk(0, 0, 2'd0, 0, 3'b010, 3'b000, 0, 0, O_CPE,  "lp_to_cpe"));
    vecs.push_back(mk(0, 0, 2'd0, 0, 3'b010, 3'b000, 0, 0, O_DEC,  "cpe_to_dec"));
    vecs.push_back(mk(0, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0, O_LFD,  "hdr1b_lfd"));
    vecs.push_back(mk(0, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0, O_LD,   "hdr1b_ld"));
    vecs.push_back(mk(0, 1, 2'd1, 1, 3'b111, 3'b000, 0, 0, O_FULL, "full_1"));
    vecs.push_back(mk(0, 1, 2'd1, 1, 3'b111, 3'b000, 0, 0, O_FULL, "full_2"));
    vecs.push_back(mk(0, 1, 2'd1, 1, 3'b111, 3'b000, 0, 0, O_FULL, "full_3"));
    vecs.push_back(mk(0, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0, O_LAF,  "full_to_laf"));
    vecs.push_back(mk(0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 1, O_LP,   "laf_lowpv_lp"));
    vecs.push_back(mk(0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_CPE,  "laf_path_cpe"));
    vecs.push_back(mk(0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_DEC,  "laf_path_dec"));
    vecs.push_back(mk(0, 1, 2'd2, 0, 3'b001, 3'b000, 0, 0, O_WTE,  "hdr2_wait"));
    vecs.push_back(mk(0, 1, 2'd2, 0, 3'b000, 3'b000, 0, 0, O_WTE,  "wait_e0_lo"));
    vecs.push_back(mk(0, 1, 2'd2, 0, 3'b001, 3'b000, 0, 0, O_WTE,  "wait_e0_hi"));
    vecs.push_back(mk(0, 1, 2'd2, 0, 3'b100, 3'b000, 0, 0, O_LFD,  "wait_e2_lfd"));
    vecs.push_back(mk(0, 1, 2'd2, 0, 3'b100, 3'b000, 0, 0, O_LD,   "p2_ld"));
    vecs.push_back(mk(0, 0, 2'd0, 0, 3'b100, 3'b000, 0, 0, O_LP,   "p2_lp"));
    vecs.push_back(mk(0, 0, 2'd0, 1, 3'b100, 3'b000, 0, 0, O_CPE,  "lp_uncond"));
    vecs.push_back(mk(0, 0, 2'd0, 1, 3'b100, 3'b000, 0, 0, O_FULL, "cpe_full"));
    vecs.push_back(mk(0, 0, 2'd0, 0, 3'b100, 3'b000, 0, 0, O_LAF,  "cpe_full_laf"));
    vecs.push_back(mk(0, 0, 2'd0, 0, 3'b100, 3'b000, 1, 1, O_DEC,  "laf_pdone"));
    vecs.push_back(mk(0, 1, 2'd3, 0, 3'b111, 3'b000, 0, 0, O_DEC,  "hdr3_drop"));
    vecs.push_back(mk(0, 1, 2'd3, 0, 3'b111, 3'b000, 0, 0, O_DEC,  "hdr3_drop2"));
    vecs.push_back(mk(0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_DEC,  "no_pv_idle"));
    vecs.push_back(mk(0, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, O_LFD,  "hdr0_lfd"));
    vecs.push_back(mk(0, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, O_LD,   "hdr0_ld"));
    vecs.push_back(mk(0, 1, 2'd0, 0, 3'b001, 3'b010, 0, 0, O_LD,   "sr1_ignored"));
    vecs.push_back(mk(0, 1, 2'd0, 0, 3'b001, 3'b100, 0, 0, O_LD,   "sr2_ignored"));
    vecs.push_back(mk(0, 1, 2'd0, 0, 3'b001, 3'b001, 0, 0, O_DEC,  "sr0_hit"));
    vecs.push_back(mk(0, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, O_LFD,  "hdr0b_lfd"));
    vecs.push_back(mk(0, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, O_LD,   "hdr0b_ld"));
    vecs.push_back(mk(0, 1, 2'd0, 1, 3'b001, 3'b000, 0, 0, O_FULL, "hdr0b_full"));
    vecs.push_back(mk(1, 1, 2'd0, 1, 3'b001, 3'b000, 0, 0, O_DEC,  "reset_in_full"));
    vecs.push_back(mk(0, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0, O_LFD,  "hdr1c_lfd"));
    vecs.push_back(mk(0, 1, 2'd1, 0, 3'b111, 3'b010, 0, 0, O_DEC,  "sr1_in_lfd"));
    vecs.push_back(mk(0, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LFD,  "hdr0c_lfd"));
    vecs.push_back(mk(0, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD,   "hdr0c_ld"));
    vecs.push_back(mk(0, 1, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FULL, "hdr0c_full"));
    vecs.push_back(mk(0, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LAF,  "hdr0c_laf"));
    vecs.push_back(mk(0, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD,   "laf_to_ld"));
    vecs.push_back(mk(0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LP,   "hdr0c_lp"));
    vecs.push_back(mk(0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_CPE,  "hdr0c_cpe"));
    vecs.push_back(mk(0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_DEC,  "hdr0c_dec"));
    vecs.push_back(mk(0, 1, 2'd2, 0, 3'b011, 3'b000, 0, 0, O_WTE,  "hdr2b_wait"));
    vecs.push_back(mk(0, 0, 2'd0, 0, 3'b011, 3'b100, 0, 0, O_DEC,  "sr2_in_wait"));

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check(vecs[i].name, vecs[i].exp_o);
      @(negedge clk);
    end

    // Hand-written: header to a busy port 1, then release it after a
    // few cycles and require LOAD_FIRST_DATA within a bounded window.
    begin
      bit seen_lfd;
      drive(mk(0, 1, 2'd1, 0, 3'b101, 3'b000, 0, 0, 8'h00, "seq"));
      @(posedge clk); #1;
      check("seq_wait_entry", O_WTE);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        src_if.pkt_valid = 1'b1;
        {fifo_empty_2, fifo_empty_0} = 2'(c);
        @(posedge clk); #1;
        check("seq_wait_hold", O_WTE);
      end
      @(negedge clk);
      fifo_empty_1 = 1'b1;
      seen_lfd = 1'b0;
      for (int c = 0; c < 5 && !seen_lfd; c++) begin
        @(posedge clk); #1;
        if (lfd_state === 1'b1) seen_lfd = 1'b1;
      end
      n_checks++;
      if (!seen_lfd) begin
        n_fail++;
        $display("FAIL seq_release_lfd: lfd_state not seen within 5 cycles, expected 1");
      end else begin
        check("seq_lfd_outputs", O_LFD);
        @(posedge clk); #1;
        check("seq_lfd_one_cycle", O_LD);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
